// File: rtl/pio_input_edge.sv
// Avalon-MM input PIO with synchroniser, per-bit edge capture (W1C), IRQ mask and level IRQ.
// Optional per-bit debounce filter enabled by defining PIO_DEBOUNCE_EN.
module pio_input_edge #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] cap_next;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             armed;
  logic             unused_wd;

  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  localparam int ARM = SYNC_STAGES + DEBOUNCE_CYCLES + 2;

  logic [15:0] db_cnt [WIDTH];

  // A bit only moves once sync_out has disagreed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filtered <= '0;
      for (int i = 0; i < WIDTH; i++)
        db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_out[i] == filtered[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] + 16'd1 == 16'(DEBOUNCE_CYCLES)) begin
          filtered[i] <= sync_out[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end
`else
  localparam int ARM = SYNC_STAGES + 1;

  logic unused_cfg;

  assign unused_cfg = ^DEBOUNCE_CYCLES;
  assign filtered   = sync_out;
`endif

  localparam int ACW = $clog2(ARM + 1);

  logic [ACW-1:0] arm_cnt;

  assign armed = (arm_cnt == ACW'(ARM));

  // Hold off capture until the chain has flushed the reset zeros
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      arm_cnt <= '0;
    else if (!armed)
      arm_cnt <= arm_cnt + ACW'(1);
  end

  always_comb begin
    if (EDGE_TYPE == 1)
      edge_det = ~filtered & prev;
    else if (EDGE_TYPE == 2)
      edge_det = filtered ^ prev;
    else
      edge_det = filtered & ~prev;
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    mask_next = irq_mask;
    clr       = '0;
    if (wr_en && address == 2'd2)
      mask_next = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd3)
      clr = writedata[WIDTH-1:0];
    cap_next = (edge_cap & ~clr) | (armed ? edge_det : '0);
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = 32'(filtered);
      2'd2:    rd_mux = 32'(irq_mask);
      2'd3:    rd_mux = 32'(edge_cap);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      prev     <= filtered;
      irq_mask <= mask_next;
      edge_cap <= cap_next;
      readdata <= rd_mux;
      irq      <= |(cap_next & mask_next);
    end
  end

endmodule
